// File: rtl/llm_rsp_packer.sv
// llm_rsp_packer: arbitrates cache/snoop 512-bit responses and serializes them into CHI DAT flits
module llm_rsp_packer #(
    parameter int DATA_W  = 512,
    parameter int FLIT_W  = 256,
    parameter int TXNID_W = 12
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [DATA_W-1:0]  cache_data,
    input  logic [TXNID_W-1:0] cache_txnid,
    input  logic               cache_valid,
    output logic               cache_ready,
    input  logic [DATA_W-1:0]  snp_data,
    input  logic [TXNID_W-1:0] snp_txnid,
    input  logic               snp_valid,
    output logic               snp_ready,
    output logic [FLIT_W-1:0]  dat_data,
    output logic [3:0]         dat_opcode,
    output logic [TXNID_W-1:0] dat_txnid,
    output logic [1:0]         dat_dataid,
    output logic               dat_last,
    output logic               dat_valid,
    input  logic               dat_ready,
    output logic               busy
);
    localparam int BEATS    = DATA_W / FLIT_W;
    localparam int BEAT_W   = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int DID_STEP = FLIT_W / 128;

    typedef enum logic {IDLE, SEND} state_t;

    state_t               r_state;
    state_t               w_next;
    logic [BEAT_W-1:0]    r_beat;
    logic                 r_rr;
    logic [DATA_W-1:0]    r_data;
    logic [TXNID_W-1:0]   r_txnid;
    logic [3:0]           r_opcode;
    logic                 w_last;

    assign w_last     = (r_beat == BEAT_W'(BEATS - 1));
    assign dat_data   = r_data[r_beat*FLIT_W +: FLIT_W];
    assign dat_opcode = r_opcode;
    assign dat_txnid  = r_txnid;
    assign dat_dataid = 2'(int'(r_beat) * DID_STEP);
    assign dat_last   = w_last;
    assign busy       = (r_state == SEND);

    // State register; reset drops any in-flight response
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // Grant one channel in IDLE (rr_ptr breaks ties: 0 favours snoop), stream flits in SEND
    always_comb begin
        w_next      = r_state;
        cache_ready = 1'b0;
        snp_ready   = 1'b0;
        dat_valid   = 1'b0;
        if (r_state == IDLE) begin
            snp_ready   = !rst && snp_valid && (!cache_valid || !r_rr);
            cache_ready = !rst && cache_valid && (!snp_valid || r_rr);
            w_next      = (snp_ready || cache_ready) ? SEND : IDLE;
        end else begin
            dat_valid = 1'b1;
            w_next    = (dat_ready && w_last) ? IDLE : SEND;
        end
    end

    // Holding register, beat counter and round-robin pointer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_beat   <= '0;
            r_rr     <= 1'b0;
            r_data   <= '0;
            r_txnid  <= '0;
            r_opcode <= 4'h0;
        end else if (snp_ready || cache_ready) begin
            r_beat   <= '0;
            r_rr     <= ~r_rr;
            r_data   <= snp_ready ? snp_data : cache_data;
            r_txnid  <= snp_ready ? snp_txnid : cache_txnid;
            r_opcode <= snp_ready ? 4'h1 : 4'h4;
        end else if (dat_valid && dat_ready && !w_last) begin
            r_beat <= r_beat + 1'b1;
        end
    end
endmodule

// File: tb/tb_llm_rsp_packer.sv
// tb_llm_rsp_packer: scoreboard bench for the response packer (256-bit and 512-bit flit builds)
module tb_llm_rsp_packer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [511:0] cache_data, snp_data;
    logic [11:0]  cache_txnid, snp_txnid;
    logic         cache_valid, snp_valid, cache_ready, snp_ready;
    logic [255:0] dat_data;
    logic [3:0]   dat_opcode;
    logic [11:0]  dat_txnid;
    logic [1:0]   dat_dataid;
    logic         dat_last, dat_valid, dat_ready, busy;

    logic [511:0] c2_data, s2_data;
    logic [11:0]  c2_txnid, s2_txnid;
    logic         c2_valid, s2_valid, c2_ready, s2_ready;
    logic [511:0] d2_data;
    logic [3:0]   d2_opcode;
    logic [11:0]  d2_txnid;
    logic [1:0]   d2_dataid;
    logic         d2_last, d2_valid, d2_ready, busy2;

    llm_rsp_packer u_dut (
        .clk(clk), .rst(rst),
        .cache_data(cache_data), .cache_txnid(cache_txnid), .cache_valid(cache_valid), .cache_ready(cache_ready),
        .snp_data(snp_data), .snp_txnid(snp_txnid), .snp_valid(snp_valid), .snp_ready(snp_ready),
        .dat_data(dat_data), .dat_opcode(dat_opcode), .dat_txnid(dat_txnid), .dat_dataid(dat_dataid),
        .dat_last(dat_last), .dat_valid(dat_valid), .dat_ready(dat_ready), .busy(busy)
    );

    llm_rsp_packer #(.FLIT_W(512)) u_dut512 (
        .clk(clk), .rst(rst),
        .cache_data(c2_data), .cache_txnid(c2_txnid), .cache_valid(c2_valid), .cache_ready(c2_ready),
        .snp_data(s2_data), .snp_txnid(s2_txnid), .snp_valid(s2_valid), .snp_ready(s2_ready),
        .dat_data(d2_data), .dat_opcode(d2_opcode), .dat_txnid(d2_txnid), .dat_dataid(d2_dataid),
        .dat_last(d2_last), .dat_valid(d2_valid), .dat_ready(d2_ready), .busy(busy2)
    );

    typedef struct packed {
        logic [255:0] d;
        logic [3:0]   op;
        logic [11:0]  id;
        logic [1:0]   did;
        logic         last;
    } flit_t;

    localparam logic [255:0] A = {64{4'hA}};
    localparam logic [255:0] B = {64{4'hB}};
    localparam logic [255:0] C = {32{8'hC3}};
    localparam logic [255:0] D = {32{8'hD4}};
    localparam logic [255:0] E = {16{16'h1E2F}};
    localparam logic [255:0] F = {16{16'h7F60}};

    flit_t          q[$];
    logic [527:0]   q2[$];
    int             n_cmp = 0;
    int             n_fail = 0;
    int             cyc = 0;
    int             last_cyc2 = -1;
    logic           stall = 1'b0;
    flit_t          prev;
    flit_t          w_cur;

    assign w_cur = {dat_data, dat_opcode, dat_txnid, dat_dataid, dat_last};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [599:0] act, input logic [599:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic push_rsp(input bit is_snp, input logic [11:0] id, input logic [511:0] d);
        for (int b = 0; b < 2; b++)
            q.push_back({d[b*256 +: 256], is_snp ? 4'h1 : 4'h4, id, 2'(b * 2), b == 1});
    endtask

    task automatic wait_grant(input logic [1:0] exp);
        bit got = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (cache_ready || snp_ready) begin
                got = 1'b1;
                break;
            end
        end
        if (got) chk("grant", {cache_ready, snp_ready}, exp);
        else begin
            n_cmp++;
            n_fail++;
            $display("FAIL grant_timeout: got none expected %0h", exp);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input bit is_snp, input logic [11:0] id, input logic [511:0] d);
        push_rsp(is_snp, id, d);
        if (is_snp) begin snp_data = d; snp_txnid = id; snp_valid = 1'b1; end
        else begin cache_data = d; cache_txnid = id; cache_valid = 1'b1; end
        wait_grant(is_snp ? 2'b01 : 2'b10);
        snp_valid   = 1'b0;
        cache_valid = 1'b0;
    endtask

    task automatic drain();
        bit done = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (q.size() == 0 && !busy) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) begin
            n_cmp++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Main scoreboard monitor: flit order/content, stall stability, no ready while busy
    always @(negedge clk) begin
        if (!rst) begin
            if (busy) chk("ready_in_send", {cache_ready, snp_ready}, 2'b00);
            if (stall) chk("stall_hold", w_cur, prev);
            if (dat_valid && dat_ready) begin
                if (q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_flit: got %0h expected none", w_cur);
                end else chk("flit", w_cur, q.pop_front());
            end
            stall = dat_valid && !dat_ready;
            prev  = w_cur;
        end else stall = 1'b0;
    end

    // Monitor for the single-flit build: content, dataid/last and repeat interval
    always @(negedge clk) begin
        if (!rst && d2_valid && d2_ready) begin
            if (q2.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_flit512: got %0h expected none", d2_data);
            end else chk("flit512", {d2_data, d2_opcode, d2_txnid}, q2.pop_front());
            chk("last_did512", {d2_dataid, d2_last}, 3'b001);
            if (last_cyc2 >= 0) chk("interval512", cyc - last_cyc2, 2);
            last_cyc2 = cyc;
        end
    end

    initial begin
        cache_data = '0; snp_data = '0; cache_txnid = '0; snp_txnid = '0;
        snp_valid = 1'b0; dat_ready = 1'b1;
        cache_valid = 1'b1;
        c2_data = '0; s2_data = '0; c2_txnid = '0; s2_txnid = '0;
        c2_valid = 1'b0; s2_valid = 1'b0; d2_ready = 1'b1;
        @(negedge clk);
        chk("reset_outputs",
            {dat_data, dat_opcode, dat_txnid, dat_dataid, dat_last, dat_valid, busy, cache_ready, snp_ready}, '0);
        cache_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;

        send(1'b0, 12'h05A, {B, A});
        chk("first_flit_timing", {dat_valid, dat_dataid, dat_last}, 4'b1_00_0);
        @(posedge clk);
        #1 chk("second_flit_timing", {dat_valid, dat_dataid, dat_last}, 4'b1_10_1);
        @(posedge clk);
        #1 chk("idle_after_last", {busy, dat_valid}, 2'b00);
        drain();

        do_reset();
        push_rsp(1'b1, 12'h101, {D, C});
        push_rsp(1'b0, 12'h202, {F, E});
        push_rsp(1'b1, 12'h101, {D, C});
        push_rsp(1'b0, 12'h202, {F, E});
        snp_data = {D, C}; snp_txnid = 12'h101; snp_valid = 1'b1;
        cache_data = {F, E}; cache_txnid = 12'h202; cache_valid = 1'b1;
        for (int g = 0; g < 4; g++) wait_grant((g % 2 == 0) ? 2'b01 : 2'b10);
        snp_valid = 1'b0;
        cache_valid = 1'b0;
        drain();

        do_reset();
        send(1'b1, 12'h111, {A, C});
        drain();
        push_rsp(1'b0, 12'h222, {B, D});
        push_rsp(1'b1, 12'h333, {E, A});
        cache_data = {B, D}; cache_txnid = 12'h222; cache_valid = 1'b1;
        snp_data = {E, A}; snp_txnid = 12'h333; snp_valid = 1'b1;
        wait_grant(2'b10);
        cache_valid = 1'b0;
        wait_grant(2'b01);
        snp_valid = 1'b0;
        drain();

        dat_ready = 1'b0;
        send(1'b0, 12'h0B7, {C, F});
        repeat (5) @(posedge clk);
        #1 dat_ready = 1'b1;
        drain();

        send(1'b0, 12'h3C3, {E, D});
        @(posedge clk);
        #2 rst = 1'b1;
        #1 chk("reset_drops_valid", {dat_valid, busy, cache_ready, snp_ready}, 4'b0000);
        q.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        send(1'b1, 12'h2D2, {A, B});
        chk("post_reset_first_flit", {dat_valid, dat_dataid, dat_opcode, dat_txnid}, {1'b1, 2'b00, 4'h1, 12'h2D2});
        drain();

        for (int g = 0; g < 3; g++) q2.push_back({{C, F}, 4'h4, 12'h4A4});
        c2_data = {C, F}; c2_txnid = 12'h4A4; c2_valid = 1'b1;
        for (int g = 0; g < 3; g++) begin
            bit got = 1'b0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (c2_ready) begin
                    got = 1'b1;
                    break;
                end
            end
            if (!got) begin
                n_cmp++;
                n_fail++;
                $display("FAIL grant512_timeout: got none expected cache_ready");
            end
            @(posedge clk);
            #1;
        end
        c2_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1 chk("queues_empty", q.size() + q2.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/llm_rsp_packer.md
Name: llm_rsp_packer

Overview:
- Sits directly downstream of the data controller. Accepts its 512-bit cache-read and snoop data responses over two valid/ready channels.
- Arbitrates between the two channels and serializes the winner into CHI DAT flits of FLIT_W bits, each carrying opcode, TxnID, DataID and a last-beat marker.
- Holds one response at a time and presents backpressure upstream until every beat of that response has been accepted.

Parameters:
- DATA_W, 512: response payload width; must be a multiple of FLIT_W.
- FLIT_W, 256: DAT flit data width; must be 128, 256 or 512.
- TXNID_W, 12: transaction ID width.
- BEATS, DATA_W/FLIT_W (derived localparam): flits per response.
- BEAT_W, max(1, clog2(BEATS)) (derived localparam): beat counter width.

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous active-high reset.
- cache_data  input  DATA_W  cache read response payload.
- cache_txnid  input  TXNID_W  TxnID of the cache response.
- cache_valid  input  1  cache response valid.
- cache_ready  output  1  cache response accepted.
- snp_data  input  DATA_W  snoop response payload.
- snp_txnid  input  TXNID_W  TxnID of the snoop response.
- snp_valid  input  1  snoop response valid.
- snp_ready  output  1  snoop response accepted.
- dat_data  output  FLIT_W  flit payload.
- dat_opcode  output  4  4'h4 CompData (cache) or 4'h1 SnpRespData (snoop).
- dat_txnid  output  TXNID_W  TxnID of the current response.
- dat_dataid  output  2  DataID of the current flit.
- dat_last  output  1  final flit of the response.
- dat_valid  output  1  flit valid.
- dat_ready  input  1  downstream accepts the flit.
- busy  output  1  a response is held (state is SEND).

Behaviour:
- Clocking and reset: single clock domain; rst is asynchronous and active-high.
- Reset values:
  - state=IDLE, beat counter=0, rr_ptr=0 (snoop is favoured first), holding register cleared.
  - All outputs are 0. dat_valid, cache_ready and snp_ready go low immediately when rst asserts.
- Reset mid-operation: the in-flight response is discarded and no further flits are emitted. After rst deasserts, the first flit comes from a fresh grant.
- IDLE state:
  - ready is asserted combinationally to exactly one channel:
    - only snp_valid high: snoop channel;
    - only cache_valid high: cache channel;
    - both high: the channel indicated by rr_ptr;
    - neither high: no ready.
  - At most one of cache_ready/snp_ready is high in any cycle. Both are always 0 in SEND.
  - On handshake (valid && ready): capture data, TxnID and opcode into the holding register; clear the beat counter; toggle rr_ptr to point at the other channel; go to SEND.
- SEND state:
  - dat_valid=1.
  - dat_data = held[beat*FLIT_W +: FLIT_W], i.e. beat 0 is the least-significant slice.
  - dat_dataid = beat*(FLIT_W/128). For 512/256 this gives 0 then 2.
  - dat_last = (beat==BEATS-1).
  - On dat_ready: if not last, beat increments; if last, go to IDLE.
  - While dat_valid && !dat_ready, every dat_* output holds stable.
- Throughput: first flit appears one cycle after the input handshake. Each response occupies BEATS+1 cycles minimum, because there is one IDLE bubble between responses.
- Arbitration fairness: rr_ptr toggles on every grant, including uncontested ones. With both channels continuously valid, grants strictly alternate.
- BEATS==1: dat_last is always 1 and dat_dataid is always 0.
- Inputs are ignored outside the handshake. Input changes during SEND do not affect the held response.
- Outputs in IDLE: dat_data, dat_txnid and dat_opcode hold their last values, but are don't-care while dat_valid=0.

Test Plan:
- Single cache response:
  - Stimulus: cache_valid=1, txnid=12'h05A, data={256'hB..., 256'hA...}, dat_ready=1.
  - Required response: handshake in cycle 0. Cycle 1 flit: data A, dataid 0, opcode 4'h4, last=0. Cycle 2 flit: data B, dataid 2, last=1. Back in IDLE at cycle 3.
- Simultaneous valid after reset:
  - Stimulus: both channels valid continuously.
  - Required response: grant order snoop, cache, snoop, cache. Opcodes alternate 4'h1/4'h4. No grant while busy=1.
- Backpressure:
  - Stimulus: dat_ready held 0 for 5 cycles during beat 0, then 1.
  - Required response: the beat-0 flit stays stable for all 5 cycles, cache_ready/snp_ready stay 0, and beat 1 follows.
- Reset mid-response:
  - Stimulus: assert rst after beat 0 is accepted.
  - Required response: dat_valid drops in the same cycle. After release, the next flit is beat 0 of a newly granted response with dataid 0.
- Parameter corner:
  - Stimulus: FLIT_W=512.
  - Required response: one flit per response with dataid=0, last=1, and a 2-cycle repeat interval under continuous traffic.
